// File: rtl/facedet_pkg.sv
// Shared defaults and FSM state type for the face-detection front end.
package facedet_pkg;

  localparam int unsigned PixWDefault     = 8;
  localparam int unsigned SumWDefault     = 24;
  localparam int unsigned MaxWidthDefault = 240;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFlush
  } ii_state_e;

endpackage

// File: rtl/ii_line_buffer.sv
// Previous-row integral store: asynchronous read, single synchronous write port.
module ii_line_buffer #(
  parameter int unsigned Depth = 240,
  parameter int unsigned DataW = 24,
  parameter int unsigned AddrW = 8
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  // Contents are deliberately not reset: row 0 never reads them.
  logic [DataW-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/integral_image_gen.sv
// Streaming integral-image generator for the Haar-filter core.
// Define INTEGRAL_SAT_EN to clamp sums at 2^SUM_W-1 and flag the clamp on err.
module integral_image_gen
  import facedet_pkg::*;
#(
  parameter int unsigned PIX_W     = PixWDefault,
  parameter int unsigned SUM_W     = SumWDefault,
  parameter int unsigned MAX_WIDTH = MaxWidthDefault
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      width,
  input  logic [15:0]      height,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  output logic             pix_ready,
  output logic             out_valid,
  output logic [SUM_W-1:0] out_data,
  output logic [31:0]      out_addr,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned AddrW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  ii_state_e        state_q, state_d;
  logic [15:0]      w_q, h_q, x_q, y_q;
  logic [31:0]      cnt_q, out_addr_q;
  logic [SUM_W-1:0] rowsum_q, out_data_q;
  logic             out_valid_q, done_q, err_q, geo_pend_q;

  logic             geo_ok, start_ok, start_bad;
  logic             accept, out_fire, last_x, last_pix, clamp;
  logic [SUM_W-1:0] rowsum_base, above_val, rowsum_new, out_new, lb_rdata;

  assign geo_ok    = (width != 16'd0) && (height != 16'd0) && (32'(width) <= MAX_WIDTH);
  assign start_ok  = (state_q == StIdle) && start && geo_ok;
  assign start_bad = (state_q == StIdle) && start && !geo_ok;

  assign pix_ready = (state_q == StRun) && (!out_valid_q || out_ready);
  assign accept    = pix_valid && pix_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign last_x    = (x_q == w_q - 16'd1);
  assign last_pix  = last_x && (y_q == h_q - 16'd1);

  assign rowsum_base = (x_q == 16'd0) ? '0 : rowsum_q;
  assign above_val   = (y_q == 16'd0) ? '0 : lb_rdata;

`ifdef INTEGRAL_SAT_EN
  localparam int unsigned WideW = SUM_W + 1;
  logic [SUM_W:0] rs_wide, od_wide;

  always_comb begin
    rs_wide    = {1'b0, rowsum_base} + WideW'(pix_data);
    rowsum_new = rs_wide[SUM_W] ? '1 : rs_wide[SUM_W-1:0];
    od_wide    = {1'b0, rowsum_new} + {1'b0, above_val};
    out_new    = od_wide[SUM_W] ? '1 : od_wide[SUM_W-1:0];
    clamp      = accept && (rs_wide[SUM_W] || od_wide[SUM_W]);
  end
`else
  always_comb begin
    rowsum_new = rowsum_base + SUM_W'(pix_data);
    out_new    = rowsum_new + above_val;
    clamp      = 1'b0;
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok) state_d = StRun;
      StRun:   if (accept && last_pix) state_d = StFlush;
      StFlush: if (out_fire) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      w_q         <= '0;
      h_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
      rowsum_q    <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      geo_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      geo_pend_q <= 1'b0;
      // Bad geometry reports done one cycle after err rises.
      done_q     <= geo_pend_q || ((state_q == StFlush) && out_fire);
      if (start_bad) begin
        err_q      <= 1'b1;
        geo_pend_q <= 1'b1;
      end
      if (start_ok) begin
        err_q <= 1'b0;
        w_q   <= width;
        h_q   <= height;
        x_q   <= '0;
        y_q   <= '0;
        cnt_q <= '0;
      end
      if (accept) begin
        rowsum_q    <= rowsum_new;
        out_data_q  <= out_new;
        out_addr_q  <= cnt_q;
        cnt_q       <= cnt_q + 32'd1;
        out_valid_q <= 1'b1;
        if (last_x) begin
          x_q <= '0;
          y_q <= y_q + 16'd1;
        end else begin
          x_q <= x_q + 16'd1;
        end
        if (clamp) err_q <= 1'b1;
      end else if (out_fire) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  ii_line_buffer #(
    .Depth (MAX_WIDTH),
    .DataW (SUM_W),
    .AddrW (AddrW)
  ) u_line_buffer (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (x_q[AddrW-1:0]),
    .wdata_i (out_new),
    .raddr_i (x_q[AddrW-1:0]),
    .rdata_o (lb_rdata)
  );

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_integral_image_gen.sv
// Randomised self-checking bench for integral_image_gen against a direct-summation model.
module tb_integral_image_gen;

`ifdef INTEGRAL_SAT_EN
  localparam int unsigned SumW = 10;
  localparam bit          Sat  = 1'b1;
`else
  localparam int unsigned SumW = 24;
  localparam bit          Sat  = 1'b0;
`endif
  localparam int unsigned PixW     = 8;
  localparam int unsigned MaxWidth = 240;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [15:0]     width = '0;
  logic [15:0]     height = '0;
  logic            pix_valid = 1'b0;
  logic [PixW-1:0] pix_data = '0;
  logic            pix_ready;
  logic            out_valid;
  logic [SumW-1:0] out_data;
  logic [31:0]     out_addr;
  logic            out_ready = 1'b0;
  logic            busy, done, err;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  integral_image_gen #(
    .PIX_W     (PixW),
    .SUM_W     (SumW),
    .MAX_WIDTH (MaxWidth)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .width     (width),
    .height    (height),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_ready (pix_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_pix_ready"}, pix_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"},  out_data, 0);
    chk({tag, "_out_addr"},  out_addr, 0);
    chk({tag, "_done"},      done, 0);
    chk({tag, "_err"},       err, 0);
    chk({tag, "_busy"},      busy, 0);
  endtask

  // pmode 0: constant pval, 1: random, 2: pval + 10*index.
  // rmode 0: ready/valid always high, 1: out_ready toggles, 2: random handshakes.
  task automatic run_frame(input int w, input int h, input int pmode, input int pval,
                           input int rmode, input bit mid_start, input int abort_at);
    logic [63:0] img[$];
    logic [63:0] exp_q[$];
    logic [63:0] sum_max, s, hold_d, hold_a;
    bit ovf, held;
    int n, nxt_pix, out_idx, cyc, d0;

    n       = w * h;
    sum_max = (64'd1 << SumW) - 64'd1;
    ovf     = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (pmode == 0)      img.push_back(64'(pval));
      else if (pmode == 1) img.push_back(64'($urandom_range(0, (1 << PixW) - 1)));
      else                 img.push_back(64'(pval + 10 * i));
    end
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        s = 0;
        for (int yy = 0; yy <= y; yy++)
          for (int xx = 0; xx <= x; xx++) s += img[yy * w + xx];
        if (s > sum_max) ovf = 1'b1;
        exp_q.push_back(Sat ? ((s > sum_max) ? sum_max : s) : (s & sum_max));
      end
    end

    start  = 1'b1;
    width  = 16'(w);
    height = 16'(h);
    step();
    start  = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("err_after_start", err, 0);

    d0 = done_seen; nxt_pix = 0; out_idx = 0; cyc = 0; held = 1'b0;
    hold_d = 0; hold_a = 0;
    while (out_idx < n && cyc < 4000) begin
      out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      pix_valid = (nxt_pix < n) && (rmode == 0 || $urandom_range(0, 3) != 0);
      pix_data  = (nxt_pix < n) ? PixW'(img[nxt_pix]) : '0;
      if (mid_start && cyc == 3) begin
        start  = 1'b1;
        width  = 16'd2;
        height = 16'd1;
      end
      #1;
      if (held) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold_d);
        chk("hold_addr", out_addr, hold_a);
      end
      if (out_valid && out_ready) begin
        chk("out_data", out_data, exp_q[out_idx]);
        chk("out_addr", out_addr, out_idx);
        out_idx++;
      end
      held   = out_valid && !out_ready;
      hold_d = 64'(out_data);
      hold_a = 64'(out_addr);
      if (pix_valid && pix_ready) nxt_pix++;
      if (abort_at != 0 && nxt_pix == abort_at) begin
        step();
        pix_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk_idle_zero("abort");
        step();
        reset = 1'b0;
        repeat (4) step();
        chk("abort_no_done", done_seen - d0, 0);
        chk("abort_busy", busy, 0);
        return;
      end
      step();
      start = 1'b0;
      cyc++;
    end
    pix_valid = 1'b0;
    out_ready = 1'b0;

    chk("frame_outputs_seen", out_idx, n);
    if (rmode == 0) chk("throughput_cycles", cyc, n + 1);
    chk("done_pulse", done, 1);
    chk("busy_at_done", busy, 0);
    chk("out_valid_at_done", out_valid, 0);
    chk("err_at_done", err, Sat && ovf);
    step();
    chk("done_cleared", done, 0);
    chk("done_count", done_seen - d0, 1);
  endtask

  task automatic bad_start(input int w, input int h);
    int d0;
    d0     = done_seen;
    start  = 1'b1;
    width  = 16'(w);
    height = 16'(h);
    step();
    start = 1'b0;
    chk("bad_err", err, 1);
    chk("bad_done_early", done, 0);
    chk("bad_busy", busy, 0);
    chk("bad_pix_ready", pix_ready, 0);
    step();
    chk("bad_done", done, 1);
    chk("bad_out_valid", out_valid, 0);
    step();
    chk("bad_done_once", done, 0);
    chk("bad_done_count", done_seen - d0, 1);
    chk("bad_out_valid2", out_valid, 0);
  endtask

  initial begin
    #2;
    chk_idle_zero("reset");
    step();
    reset = 1'b0;
    step();

    run_frame(3, 3, 0, 1, 0, 1'b0, 0);     // all ones, full throughput
    run_frame(2, 2, 2, 10, 1, 1'b0, 0);    // 10,20,30,40 with toggling ready
    bad_start(241, 3);
    bad_start(4, 0);
    bad_start(0, 4);
    run_frame(8, 8, 1, 0, 0, 1'b0, 5);     // reset after 5 accepted pixels
    run_frame(2, 2, 0, 255, 0, 1'b0, 0);
    run_frame(3, 3, 0, 255, 0, 1'b0, 0);
    run_frame(4, 3, 1, 0, 0, 1'b1, 0);     // ignored mid-frame start
    run_frame(5, 2, 1, 0, 2, 1'b1, 0);
    run_frame(1, 1, 1, 0, 0, 1'b0, 0);
    run_frame(1, 4, 1, 0, 2, 1'b0, 0);
    run_frame(MaxWidth, 2, 0, 1, 0, 1'b0, 0);
    for (int k = 0; k < 6; k++)
      run_frame($urandom_range(1, 12), $urandom_range(1, 5), 1, 0, 2, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
